// File: rtl/ahb_apb_bridge_ctrl_if.sv
// Bus bundle between the AHB slave side and the APB master side of the bridge controller.
// The slave modport is the controller's view; master is the surrounding system's view.
interface ahb_apb_bridge_ctrl_if #(
    parameter int unsigned NUM_SLV = 4
);
    logic [1:0]         Htrans;
    logic [31:0]        Haddr;
    logic               Hwrite;
    logic [31:0]        Hwdata;
    logic [2:0]         Hsize;
    logic [2:0]         Hburst;
    logic               Hreadyin;
    logic               Hreadyout;
    logic [1:0]         Hresp;
    logic [31:0]        Hrdata;
    logic [31:0]        Prdata;
    logic [31:0]        Paddr;
    logic [31:0]        Pwdata;
    logic               Pwrite;
    logic [NUM_SLV-1:0] Pselx;
    logic               Penable;

    modport slave (
        input  Htrans, Haddr, Hwrite, Hwdata, Hsize, Hburst, Hreadyin, Prdata,
        output Hreadyout, Hresp, Hrdata, Paddr, Pwdata, Pwrite, Pselx, Penable
    );

    modport master (
        output Htrans, Haddr, Hwrite, Hwdata, Hsize, Hburst, Hreadyin, Prdata,
        input  Hreadyout, Hresp, Hrdata, Paddr, Pwdata, Pwrite, Pselx, Penable
    );
endinterface

// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-to-APB bridge sequencer: decodes single AHB beats to one of NUM_SLV APB peripherals,
// runs SETUP/ENABLE, and answers AHB with three wait states (or a two-cycle ERROR).
//   state  | meaning
//   IDLE   | ready, accepts a transfer
//   WDATA  | first data-phase cycle, captures Hwdata
//   SETUP  | APB select asserted, Penable low
//   ENABLE | Penable high, Prdata captured on reads
//   ERR1   | undecoded address, ERROR with wait state
//   ERR2   | ERROR completes, may accept next transfer
module ahb_apb_bridge_ctrl #(
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int unsigned SLV_SIZE_LOG2 = 26,
    parameter int unsigned NUM_SLV       = 4
) (
    input  logic                 clk,
    input  logic                 Hreset,
    ahb_apb_bridge_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ENABLE,
        ERR1,
        ERR2
    } state_e;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    state_e             state_q;
    logic               hreadyout_q;
    logic [1:0]         hresp_q;
    logic [31:0]        hrdata_q;
    logic [31:0]        paddr_q;
    logic [31:0]        pwdata_q;
    logic               pwrite_q;
    logic [NUM_SLV-1:0] pselx_q;
    logic               penable_q;
    logic [31:0]        addr_q;
    logic               write_q;
    logic [NUM_SLV-1:0] sel_q;

    logic [31:0]        offset;
    logic [31:0]        idx;
    logic               decoded;
    logic               valid;
    logic [NUM_SLV-1:0] sel_d;

    // Offset wraps for addresses below the window; the >= test rejects those.
    always_comb begin
        offset  = bus.Haddr - BASE_ADDR;
        idx     = offset >> SLV_SIZE_LOG2;
        decoded = (bus.Haddr >= BASE_ADDR) && (idx < NUM_SLV);
        sel_d   = '0;
        if (decoded) begin
            sel_d = NUM_SLV'(1) << idx;
        end
        valid   = bus.Htrans[1] && bus.Hreadyin && hreadyout_q;
    end

    always_ff @(posedge clk or posedge Hreset) begin
        if (Hreset) begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
            hrdata_q    <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            sel_q       <= '0;
        end else begin
            case (state_q)
                IDLE, ERR2: begin
                    if (valid && decoded) begin
                        state_q     <= WDATA;
                        addr_q      <= bus.Haddr;
                        write_q     <= bus.Hwrite;
                        sel_q       <= sel_d;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= RESP_OKAY;
                    end else if (valid) begin
                        state_q     <= ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= RESP_ERROR;
                    end else begin
                        state_q     <= IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= RESP_OKAY;
                    end
                end
                WDATA: begin
                    state_q   <= SETUP;
                    pselx_q   <= sel_q;
                    penable_q <= 1'b0;
                    paddr_q   <= addr_q;
                    pwrite_q  <= write_q;
                    pwdata_q  <= bus.Hwdata;
                end
                SETUP: begin
                    state_q   <= ENABLE;
                    penable_q <= 1'b1;
                end
                ENABLE: begin
                    if (!pwrite_q) begin
                        hrdata_q <= bus.Prdata;
                    end
                    state_q     <= IDLE;
                    pselx_q     <= '0;
                    penable_q   <= 1'b0;
                    hreadyout_q <= 1'b1;
                end
                ERR1: begin
                    state_q     <= ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= RESP_ERROR;
                end
                default: begin
                    state_q     <= IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= RESP_OKAY;
                    pselx_q     <= '0;
                    penable_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Hreadyout = hreadyout_q;
    assign bus.Hresp     = hresp_q;
    assign bus.Hrdata    = hrdata_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Pselx     = pselx_q;
    assign bus.Penable   = penable_q;

    // Size and burst carry no information for this bridge.
    logic unused_hsize_hburst;
    assign unused_hsize_hburst = ^{bus.Hsize, bus.Hburst};

endmodule

// File: doc/ahb_apb_bridge_ctrl.md
Name: ahb_apb_bridge_ctrl

Overview:
- Sequencing controller between the AHB slave port and the APB master port of the bridge.
- Accepts single AHB transfers and decodes the address to one of NUM_SLV APB peripherals.
- Runs the APB SETUP/ENABLE protocol and returns read data and response to AHB using Hreadyout wait states.
- Out-of-range addresses get a two-cycle AHB ERROR response with no APB activity.

Parameters:
BASE_ADDR, 32'h8000_0000, base of the APB address window
SLV_SIZE_LOG2, 26, log2 of bytes decoded per peripheral (64 MB each)
NUM_SLV, 4, number of APB peripherals; width of Pselx

Ports:
clk  in  1  system clock, all logic on posedge
Hreset  in  1  asynchronous active-high reset
Htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
Haddr  in  32  AHB address
Hwrite  in  1  AHB direction, 1 = write
Hwdata  in  32  AHB write data (data phase)
Hsize  in  3  AHB size; ignored, all transfers are 32-bit
Hburst  in  3  AHB burst; ignored, each beat is sequenced independently
Hreadyin  in  1  AHB bus ready
Hreadyout  out  1  slave ready; 0 inserts a wait state
Hresp  out  2  00 OKAY, 01 ERROR
Hrdata  out  32  read data returned to AHB
Prdata  in  32  APB read data
Paddr  out  32  APB address
Pwdata  out  32  APB write data
Pwrite  out  1  APB direction
Pselx  out  NUM_SLV  one-hot APB select
Penable  out  1  APB enable

Behaviour:
- Reset: Hreset is asynchronous and active-high. While Hreset=1: state=IDLE, Hreadyout=1, Hresp=00, Hrdata=0, Paddr=0, Pwdata=0, Pwrite=0, Pselx=0, Penable=0.
- Reset mid-operation aborts the transfer immediately; Pselx and Penable drop without waiting for a clock edge.
- All outputs are registered.
- Valid transfer = Htrans[1]=1 AND Hreadyin=1 AND Hreadyout=1, sampled at posedge. Transfers are accepted only in IDLE or ERR2.
- BUSY and IDLE Htrans are never accepted and always get an OKAY response.
- Decode:
  - idx = (Haddr - BASE_ADDR) >> SLV_SIZE_LOG2.
  - Decoded when Haddr >= BASE_ADDR and idx < NUM_SLV; then sel = 1<<idx.
  - Any other address is undecoded.
- FSM states: IDLE, WDATA, SETUP, ENABLE, ERR1, ERR2.
  - IDLE: Hreadyout=1, Hresp=00. Valid and decoded: latch Haddr, Hwrite, sel; go to WDATA. Valid and undecoded: go to ERR1. Otherwise stay.
  - WDATA: Hreadyout=0. Latch Hwdata (valid in this first data-phase cycle); go to SETUP.
  - SETUP: Pselx=sel, Penable=0, Paddr/Pwrite/Pwdata from latches, Hreadyout=0; go to ENABLE.
  - ENABLE: Pselx=sel, Penable=1, address/data held, Hreadyout=0. At the end of the cycle, Hrdata <= Prdata if read; Hrdata is unchanged on write. Go to IDLE with Pselx=0, Penable=0, Hreadyout=1.
  - ERR1: Hreadyout=0, Hresp=01, no APB select; go to ERR2.
  - ERR2: Hreadyout=1, Hresp=01. Accepts a new transfer exactly as IDLE does; otherwise go to IDLE.
- Latency: data phase is 4 cycles (3 wait states) for reads and writes. Back-to-back transfers repeat every 4 cycles.
- Pipelining: the cycle in which Hreadyout returns to 1 completes the previous data phase and may also accept the next address phase.
- Paddr, Pwrite, Pwdata are stable from SETUP through ENABLE. Between transfers they hold their last values; only Pselx and Penable return to 0.
- Hrdata holds its last read value until the next read completes.
- The APB side has no ready/slverr: ENABLE is always exactly one cycle.

Test Plan:
- Reset: assert Hreset mid-ENABLE -> same-cycle Pselx=0, Penable=0, Hreadyout=1, Hrdata=0; after release, idle bus gives no APB activity.
- Write: NONSEQ write Haddr=32'h8000_0010, Hwdata=32'hDEAD_BEEF -> SETUP cycle: Pselx=0001, Penable=0, Pwrite=1, Paddr=32'h8000_0010, Pwdata=32'hDEAD_BEEF; next cycle Penable=1; Hreadyout low 3 cycles, Hresp=00.
- Read: NONSEQ read Haddr=32'h8C00_0004 with Prdata=32'h1234_5678 during ENABLE -> Pselx=1000, Pwrite=0; Hrdata=32'h1234_5678 when Hreadyout returns to 1, Hresp=00.
- Back-to-back: INCR4 SEQ reads at 32'h8400_0000..0C -> four SETUP/ENABLE pairs on Pselx=0010 with Paddr incrementing by 4; each next address accepted in the Hreadyout=1 cycle.
- Error: NONSEQ to Haddr=32'h9000_0000 -> Pselx stays 0; ERR1 gives Hreadyout=0, Hresp=01; ERR2 gives Hreadyout=1, Hresp=01; an immediately following valid write at 32'h8000_0000 then completes with OKAY.
- Ignore: Htrans=01 (BUSY), and separately Htrans=10 with Hreadyin=0 -> no state change, Hreadyout=1, Hresp=00, no APB select.
